// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// operation encoding and pipeline geometry helpers.
package cla_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int stages(input int width, input int block);
    return width / block;
  endfunction

  // Operands must split into a whole number of non-empty slices.
  function automatic bit geometry_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice; every carry is a flat
// sum of products of generate/propagate terms and the slice carry-in.
module cla_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   carry;
  logic             term;

  assign g = a & b;
  assign p = a | b;

  // NOTE: every variable written here gets a value before any branch or loop
  // reads it, so no storage (latch) is inferred.
  always_comb begin
    carry    = '0;
    term     = 1'b0;
    carry[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      term = cin;
      for (int j = 0; j <= i; j++) term = term & p[j];
      carry[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        carry[i+1] = carry[i+1] | term;
      end
    end
  end

  assign sum   = a ^ b ^ carry[BLOCK-1:0];
  assign cout  = carry[BLOCK];
  assign c_msb = carry[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor, one BLOCK-bit slice per stage, valid/ready
// stream with backpressure. Define CLA_SAT_EN for signed saturation of results.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int STAGES = stages(WIDTH, BLOCK);

  if (!geometry_ok(WIDTH, BLOCK)) begin : g_bad_geometry
    $error("pipelined_cla_addsub: WIDTH must be a positive multiple of BLOCK");
  end

  logic [STAGES-1:0] valid_q;
  logic              advance;
  logic [WIDTH-1:0]  b_eff;
  logic              c0;
  logic [WIDTH-1:0]  result_q;
  logic              cout_q;
  logic              ovf_q;

  // The whole pipe moves together; bubbles are not squeezed out.
  assign advance  = i_ready | ~valid_q[STAGES-1];
  assign o_ready  = advance;
  assign o_valid  = valid_q[STAGES-1];
  assign o_result = result_q;
  assign o_cout   = cout_q;
  assign o_ovf    = ovf_q;

  assign b_eff = (i_sub == OP_ADD) ? i_add2 : ~i_add2;
  assign c0    = (i_sub == OP_SUB) ? 1'b1 : i_cin;

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // its neighbour's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (advance) valid_q <= (valid_q << 1) | STAGES'(i_valid);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - k * BLOCK;   // operand bits still to resolve
    localparam int HI  = (k + 1) * BLOCK;     // result bits known after this stage

    logic [REM-1:0]   a_in;
    logic [REM-1:0]   b_in;
    logic             cin_in;
    logic             v_in;
    logic [BLOCK-1:0] sum;
    logic             cout;
    logic             c_msb;
    logic [HI-1:0]    res_d;

    if (k == 0) begin : g_src
      assign a_in   = i_add1;
      assign b_in   = b_eff;
      assign cin_in = c0;
      assign v_in   = i_valid;
      assign res_d  = sum;
    end else begin : g_src
      assign a_in   = g_st[k-1].g_fwd.a_q;
      assign b_in   = g_st[k-1].g_fwd.b_q;
      assign cin_in = g_st[k-1].g_fwd.c_q;
      assign v_in   = valid_q[k-1];
      assign res_d  = {sum, g_st[k-1].g_fwd.res_q};
    end

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a    (a_in[BLOCK-1:0]),
      .b    (b_in[BLOCK-1:0]),
      .cin  (cin_in),
      .sum  (sum),
      .cout (cout),
      .c_msb(c_msb)
    );

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-BLOCK-1:0] a_q;
      logic [REM-BLOCK-1:0] b_q;
      logic [HI-1:0]        res_q;
      logic                 c_q;
      logic                 unused_c_msb;

      assign unused_c_msb = c_msb;

      // NOTE: data registers load only for real beats; with valid low the
      // stale contents are never observed, so they simply hold.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          res_q <= '0;
          c_q   <= 1'b0;
        end else if (advance && v_in) begin
          a_q   <= a_in[REM-1:BLOCK];
          b_q   <= b_in[REM-1:BLOCK];
          res_q <= res_d;
          c_q   <= cout;
        end
      end
    end else begin : g_last
      logic             ovf;
      logic [WIDTH-1:0] res_final;

      assign ovf = cout ^ c_msb;

`ifdef CLA_SAT_EN
      localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
      // Overflow can only go past the rail that A's sign points at.
      assign res_final = !ovf ? res_d : (a_in[BLOCK-1] ? ~SAT_MAX : SAT_MAX);
`else
      assign res_final = res_d;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          result_q <= '0;
          cout_q   <= 1'b0;
          ovf_q    <= 1'b0;
        end else if (advance && v_in) begin
          result_q <= res_final;
          cout_q   <= cout;
          ovf_q    <= ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Self-checking bench for pipelined_cla_addsub (WIDTH 16, BLOCK 4); honours
// CLA_SAT_EN so the same bench covers the saturating build.
module tb_pipelined_cla_addsub;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int LAT   = WIDTH / BLOCK;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add1;
  logic [WIDTH-1:0] i_add2;
  logic             i_sub;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_result;
  logic             o_cout;
  logic             o_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_add1  (i_add1),
    .i_add2  (i_add2),
    .i_sub   (i_sub),
    .i_cin   (i_cin),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_cout  (o_cout),
    .o_ovf   (o_ovf)
  );

  // Reference: exact integer arithmetic, then wrap / saturate.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic cin);
    int ua, ub, sa, sb, exact;
    logic [15:0] res;
    logic cout, ovf;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      exact = sa - sb;
      cout  = (ua >= ub);
      res   = 16'(ua - ub);
    end else begin
      exact = sa + sb + int'(cin);
      cout  = (ua + ub + int'(cin)) > 65535;
      res   = 16'(ua + ub + int'(cin));
    end
    ovf = (exact > 32767) || (exact < -32768);
`ifdef CLA_SAT_EN
    if (ovf) res = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {res, cout, ovf};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: pops on output transfers, pushes on accepts.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && i_ready) begin
        check("out_has_pending_beat", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          check("scoreboard", 32'({o_result, o_cout, o_ovf}), 32'(exp_q.pop_front()));
        n_out++;
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_add1, i_add2, i_sub, i_cin));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_beat(input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin);
    i_valid = 1'b1;
    i_add1  = a;
    i_add2  = b;
    i_sub   = sub;
    i_cin   = cin;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_add1  = '0;
    i_add2  = '0;
    i_sub   = 1'b0;
    i_cin   = 1'b0;
  endtask

  task automatic set_random();
    set_beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_single(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic sub, input logic cin, input logic [15:0] er,
                            input logic ec, input logic eo);
    int cyc;
    set_beat(a, b, sub, cin);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    tick();
    idle();
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(LAT - 1));
    check({tag, "_result"}, 32'(o_result), 32'(er));
    check({tag, "_cout"}, 32'(o_cout), 32'(ec));
    check({tag, "_ovf"}, 32'(o_ovf), 32'(eo));
    tick();
  endtask

  initial begin
    int first_t, last_t, run, sent, c, outs0, cyc, n_stall;
    logic acc, prev_stall;
    logic [17:0] held;

    rst = 1'b1;
    i_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #2;
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_result", 32'(o_result), 32'd0);
    check("reset_o_cout", 32'(o_cout), 32'd0);
    check("reset_o_ovf", 32'(o_ovf), 32'd0);
    check("reset_o_ready", 32'(o_ready), 32'd1);
    rst = 1'b0;
    tick();

`ifdef CLA_SAT_EN
    run_single("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
    run_single("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    run_single("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_single("add_cin", 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h1235, 1'b0, 1'b0);
    run_single("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef CLA_SAT_EN
    run_single("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8000, 1'b1, 1'b1);
`else
    run_single("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`endif

    // Back-to-back stream of 8 random beats.
    i_ready = 1'b1;
    set_random();
    tick();
    first_t = -1;
    last_t  = -1;
    run     = 0;
    for (int t = 0; t < 14; t++) begin
      if (o_valid) begin
        if (first_t < 0) first_t = t;
        last_t = t;
        run++;
      end
      if (t + 1 < 8) set_random();
      else idle();
      tick();
    end
    check("stream_first_valid", 32'(first_t), 32'(LAT - 1));
    check("stream_valid_count", 32'(run), 32'd8);
    check("stream_valid_span", 32'(last_t - first_t + 1), 32'd8);

    // Six beats with downstream stalled for three cycles.
    outs0      = n_out;
    sent       = 0;
    c          = 0;
    n_stall    = 0;
    prev_stall = 1'b0;
    held       = '0;
    set_random();
    while ((sent < 6 || exp_q.size() > 0) && c < 60) begin
      i_ready = !(c >= 5 && c < 8);
      if (sent >= 6) idle();
      #1;
      if (o_valid && !i_ready) begin
        n_stall++;
        check("stall_o_ready", 32'(o_ready), 32'd0);
        if (prev_stall) check("stall_hold", 32'({o_result, o_cout, o_ovf}), 32'(held));
        held = {o_result, o_cout, o_ovf};
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      acc = i_valid && o_ready;
      tick();
      if (acc) begin
        sent++;
        if (sent < 6) set_random();
      end
      c++;
    end
    i_ready = 1'b1;
    idle();
    check("stall_cycles", 32'(n_stall), 32'd3);
    check("stall_stream_outputs", 32'(n_out - outs0), 32'd6);
    check("stall_stream_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with three beats in flight.
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_random();
      check("inflight_ready", 32'(o_ready), 32'd1);
      tick();
    end
    idle();
    cyc = 0;
    while (!o_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("inflight_o_valid", 32'(o_valid), 32'd1);
    check("inflight_pending", 32'(exp_q.size()), 32'd3);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_o_valid", 32'(o_valid), 32'd0);
    check("async_rst_o_result", 32'(o_result), 32'd0);
    check("async_rst_o_ready", 32'(o_ready), 32'd1);
    tick();
    tick();
    #1 rst = 1'b0;
    i_ready = 1'b1;
    run = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (o_valid) run++;
    end
    check("post_rst_no_stale", 32'(run), 32'd0);
    run_single("post_rst_add", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
